// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//   Parses a PS/2 set-2 scan-code byte stream into key events. The parser
//   handles the make, break (F0) and extended (E0) prefixes. The block tracks
//   the held key, flags typematic repeats and counts key presses. Events are
//   buffered in a first-word-fall-through FIFO that has a valid/ready output.
//
// Ports
//   clk, resetn        : rising-edge clock, asynchronous active-low reset
//   byte_data/_valid   : received scan-code byte plus its one-cycle strobe
//   evt_valid/_ready   : output handshake. The head entry is transferred on a
//                        cycle where evt_valid && evt_ready. evt_valid never
//                        depends on evt_ready. evt_* are held stable while
//                        evt_valid=1 and evt_ready=0. evt_ready is ignored
//                        while evt_valid=0.
//   evt_code/ext/break/repeat : fields of the FIFO head entry
//   held_code/ext/valid: the key that is currently held down
//   press_cnt          : number of non-repeat make events since reset
//   fifo_level         : number of entries in the FIFO
//   overflow           : sticky flag, set when an event is dropped on a full FIFO
//   dbg_state          : current parser state
//                        (0 = IDLE, 1 = EXT, 2 = BRK, 3 = EXT_BRK)
module ps2_key_tracker #(
    parameter int FIFO_DEPTH      = 8,
    parameter int CNT_WIDTH       = 16,
    parameter bit SUPPRESS_REPEAT = 1'b0
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [7:0]                    byte_data,
    input  logic                          byte_valid,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [7:0]                    evt_code,
    output logic                          evt_ext,
    output logic                          evt_break,
    output logic                          evt_repeat,
    output logic [7:0]                    held_code,
    output logic                          held_ext,
    output logic                          held_valid,
    output logic [CNT_WIDTH-1:0]          press_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [1:0]                    dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [7:0]             held_code_q, held_code_d;
    logic                   held_ext_q, held_ext_d;
    logic                   held_valid_q, held_valid_d;
    logic [CNT_WIDTH-1:0]   press_cnt_q, press_cnt_d;
    logic [10:0]            mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]          level_q, level_d;
    logic                   overflow_q;

    logic       ev_fire, ev_ext, ev_brk, ev_match, ev_rep;
    logic       push, pop, full, wr_en;
    logic [10:0] head;

    // Parser. An event completes on any byte that is not a prefix. A new E0
    // always restarts the sequence as an extended prefix.
    always_comb begin
        state_d = state_q;
        ev_fire = 1'b0;
        ev_ext  = 1'b0;
        ev_brk  = 1'b0;
        if (byte_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (byte_data == 8'hE0)      state_d = ST_EXT;
                    else if (byte_data == 8'hF0) state_d = ST_BRK;
                    else                         ev_fire = 1'b1;
                end
                ST_EXT: begin
                    if (byte_data == 8'hF0)      state_d = ST_EXT_BRK;
                    else if (byte_data == 8'hE0) state_d = ST_EXT;
                    else begin
                        ev_fire = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    if (byte_data == 8'hE0)      state_d = ST_EXT;
                    else if (byte_data == 8'hF0) state_d = ST_BRK;
                    else begin
                        ev_fire = 1'b1;
                        ev_brk  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    if (byte_data == 8'hE0)      state_d = ST_EXT;
                    else if (byte_data == 8'hF0) state_d = ST_EXT_BRK;
                    else begin
                        ev_fire = 1'b1;
                        ev_ext  = 1'b1;
                        ev_brk  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Classification against the held key, in the same cycle as the
    // completing byte.
    assign ev_match = held_valid_q && (held_ext_q == ev_ext) && (held_code_q == byte_data);
    assign ev_rep   = ev_fire && !ev_brk && ev_match;

    always_comb begin
        held_code_d  = held_code_q;
        held_ext_d   = held_ext_q;
        held_valid_d = held_valid_q;
        press_cnt_d  = press_cnt_q;
        if (ev_fire && !ev_brk && !ev_match) begin
            held_code_d  = byte_data;
            held_ext_d   = ev_ext;
            held_valid_d = 1'b1;
            press_cnt_d  = press_cnt_q + 1'b1;
        end else if (ev_fire && ev_brk && ev_match) begin
            // On release, keep the last code visible and clear only the valid flag.
            held_valid_d = 1'b0;
        end
    end

    // FIFO control. A pop needs a non-empty FIFO, so a push into an empty
    // FIFO always wins. When the FIFO is full, a same-cycle pop frees the
    // slot that the push uses.
    assign push    = ev_fire && !(ev_rep && SUPPRESS_REPEAT);
    assign pop     = (level_q != '0) && evt_ready;
    assign full    = (level_q == LW'(FIFO_DEPTH));
    assign wr_en   = push && (!full || pop);
    assign level_d = level_q + LW'(wr_en) - LW'(pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            held_code_q  <= '0;
            held_ext_q   <= 1'b0;
            held_valid_q <= 1'b0;
            press_cnt_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            held_code_q  <= held_code_d;
            held_ext_q   <= held_ext_d;
            held_valid_q <= held_valid_d;
            press_cnt_q  <= press_cnt_d;
            level_q      <= level_d;
            if (wr_en) begin
                mem_q[wr_ptr_q] <= {ev_rep, ev_ext, ev_brk, byte_data};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && full && !pop) overflow_q <= 1'b1;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign evt_valid  = (level_q != '0);
    assign evt_repeat = head[10];
    assign evt_ext    = head[9];
    assign evt_break  = head[8];
    assign evt_code   = head[7:0];
    assign held_code  = held_code_q;
    assign held_ext   = held_ext_q;
    assign held_valid = held_valid_q;
    assign press_cnt  = press_cnt_q;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker. It drives two instances from the same byte
// stream. dut_a uses FIFO_DEPTH=4 with repeats tagged. dut_b uses
// FIFO_DEPTH=8 with repeats suppressed.
module tb_ps2_key_tracker;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_valid = 1'b0;
    logic        evt_ready = 1'b0;

    logic        a_valid, a_ext, a_brk, a_rep, a_hext, a_hval, a_ovf;
    logic [7:0]  a_code, a_hcode;
    logic [15:0] a_cnt;
    logic [2:0]  a_level;
    logic [1:0]  a_state;

    logic        b_valid, b_ext, b_brk, b_rep, b_hext, b_hval, b_ovf;
    logic [7:0]  b_code, b_hcode;
    logic [15:0] b_cnt;
    logic [3:0]  b_level;
    logic [1:0]  b_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] exp_q[$];
    logic [10:0] exp_b_q[$];

    typedef struct {
        logic [7:0]  b;
        logic        ev;
        logic [10:0] evt;
        logic        hv;
        logic [7:0]  hc;
        logic        he;
        logic [15:0] pc;
    } vec_t;
    vec_t tbl[$];

    ps2_key_tracker #(.FIFO_DEPTH(4), .CNT_WIDTH(16), .SUPPRESS_REPEAT(1'b0)) dut_a (
        .clk(clk), .resetn(resetn), .byte_data(byte_data), .byte_valid(byte_valid),
        .evt_valid(a_valid), .evt_ready(evt_ready), .evt_code(a_code), .evt_ext(a_ext),
        .evt_break(a_brk), .evt_repeat(a_rep), .held_code(a_hcode), .held_ext(a_hext),
        .held_valid(a_hval), .press_cnt(a_cnt), .fifo_level(a_level), .overflow(a_ovf),
        .dbg_state(a_state)
    );

    ps2_key_tracker #(.FIFO_DEPTH(8), .CNT_WIDTH(16), .SUPPRESS_REPEAT(1'b1)) dut_b (
        .clk(clk), .resetn(resetn), .byte_data(byte_data), .byte_valid(byte_valid),
        .evt_valid(b_valid), .evt_ready(evt_ready), .evt_code(b_code), .evt_ext(b_ext),
        .evt_break(b_brk), .evt_repeat(b_rep), .held_code(b_hcode), .held_ext(b_hext),
        .held_valid(b_hval), .press_cnt(b_cnt), .fifo_level(b_level), .overflow(b_ovf),
        .dbg_state(b_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " a_evt_valid"}, 32'(a_valid), 0);
        chk({tag, " a_evt_fields"}, 32'({a_rep, a_ext, a_brk, a_code}), 0);
        chk({tag, " a_held"}, 32'({a_hval, a_hext, a_hcode}), 0);
        chk({tag, " a_press_cnt"}, 32'(a_cnt), 0);
        chk({tag, " a_level"}, 32'(a_level), 0);
        chk({tag, " a_overflow"}, 32'(a_ovf), 0);
        chk({tag, " b_all"}, 32'({b_valid, b_rep, b_ext, b_brk, b_code, b_hval, b_hext,
                                   b_hcode, b_level, b_ovf}), 0);
        chk({tag, " b_press_cnt"}, 32'(b_cnt), 0);
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        byte_valid = 1'b0;
        evt_ready = 1'b0;
        exp_q.delete();
        exp_b_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        resetn = 1'b1;
    endtask

    // Driver: a one-cycle byte strobe. This returns #1 after the edge that
    // completes the byte.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        byte_data  = b;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int cyc;
        evt_ready = 1'b1;
        cyc = 0;
        while ((exp_q.size() != 0 || exp_b_q.size() != 0 || a_valid || b_valid) && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, " drain_timeout"}, 32'(cyc < 50), 1);
    endtask

    task automatic add(input logic [7:0] b, input logic ev, input logic [10:0] evt,
                       input logic hv, input logic [7:0] hc, input logic he,
                       input logic [15:0] pc);
        vec_t v;
        v.b = b; v.ev = ev; v.evt = evt; v.hv = hv; v.hc = hc; v.he = he; v.pc = pc;
        tbl.push_back(v);
    endtask

    // Scoreboard: the head is compared on each cycle where a transfer happens.
    always @(negedge clk) begin
        if (resetn && a_valid && evt_ready) begin
            if (exp_q.size() == 0) chk("a_unexpected_event", 32'({a_rep, a_ext, a_brk, a_code}), 32'h7FF);
            else chk("a_event", 32'({a_rep, a_ext, a_brk, a_code}), 32'(exp_q.pop_front()));
        end
        if (resetn && b_valid && evt_ready) begin
            if (exp_b_q.size() == 0) chk("b_unexpected_event", 32'({b_rep, b_ext, b_brk, b_code}), 32'h7FF);
            else chk("b_event", 32'({b_rep, b_ext, b_brk, b_code}), 32'(exp_b_q.pop_front()));
        end
    end

    initial begin
        // Vector table: the byte, the event it completes as {rep,ext,brk,code},
        // and the held/press state expected afterwards.
        add(8'h1C, 1, 11'h01C, 1, 8'h1C, 0, 1);
        add(8'hF0, 0, 11'h000, 1, 8'h1C, 0, 1);
        add(8'h1C, 1, 11'h11C, 0, 8'h1C, 0, 1);
        add(8'hE0, 0, 11'h000, 0, 8'h1C, 0, 1);
        add(8'h75, 1, 11'h275, 1, 8'h75, 1, 2);
        add(8'hE0, 0, 11'h000, 1, 8'h75, 1, 2);
        add(8'hF0, 0, 11'h000, 1, 8'h75, 1, 2);
        add(8'h75, 1, 11'h375, 0, 8'h75, 1, 2);
        add(8'h1C, 1, 11'h01C, 1, 8'h1C, 0, 3);
        add(8'h1C, 1, 11'h41C, 1, 8'h1C, 0, 3);
        add(8'h1C, 1, 11'h41C, 1, 8'h1C, 0, 3);
        add(8'hF0, 0, 11'h000, 1, 8'h1C, 0, 3);
        add(8'h1C, 1, 11'h11C, 0, 8'h1C, 0, 3);
        add(8'hE0, 0, 11'h000, 0, 8'h1C, 0, 3);
        add(8'h1C, 1, 11'h21C, 1, 8'h1C, 1, 4);
        add(8'h1C, 1, 11'h01C, 1, 8'h1C, 0, 5);
        add(8'hF0, 0, 11'h000, 1, 8'h1C, 0, 5);
        add(8'hE0, 0, 11'h000, 1, 8'h1C, 0, 5);
        add(8'h1C, 1, 11'h21C, 1, 8'h1C, 1, 6);
        add(8'hE0, 0, 11'h000, 1, 8'h1C, 1, 6);
        add(8'hF0, 0, 11'h000, 1, 8'h1C, 1, 6);
        add(8'h1C, 1, 11'h31C, 0, 8'h1C, 1, 6);
        add(8'hF0, 0, 11'h000, 0, 8'h1C, 1, 6);
        add(8'h2A, 1, 11'h12A, 0, 8'h1C, 1, 6);
        add(8'hAA, 1, 11'h0AA, 1, 8'hAA, 0, 7);
        add(8'hFA, 1, 11'h0FA, 1, 8'hFA, 0, 8);
        add(8'hE1, 1, 11'h0E1, 1, 8'hE1, 0, 9);
        add(8'hE1, 1, 11'h4E1, 1, 8'hE1, 0, 9);
        add(8'hF0, 0, 11'h000, 1, 8'hE1, 0, 9);
        add(8'hF0, 0, 11'h000, 1, 8'hE1, 0, 9);
        add(8'hE1, 1, 11'h1E1, 0, 8'hE1, 0, 9);

        do_reset();
        evt_ready = 1'b1;
        foreach (tbl[i]) begin
            if (tbl[i].ev) begin
                exp_q.push_back(tbl[i].evt);
                if (!tbl[i].evt[10]) exp_b_q.push_back(tbl[i].evt);
            end
            send_byte(tbl[i].b);
            chk($sformatf("v%0d held_valid", i), 32'(a_hval), 32'(tbl[i].hv));
            chk($sformatf("v%0d held_code", i), 32'(a_hcode), 32'(tbl[i].hc));
            chk($sformatf("v%0d held_ext", i), 32'(a_hext), 32'(tbl[i].he));
            chk($sformatf("v%0d press_cnt", i), 32'(a_cnt), 32'(tbl[i].pc));
            chk($sformatf("v%0d b_press_cnt", i), 32'(b_cnt), 32'(tbl[i].pc));
            // A push into an empty FIFO is accepted even with evt_ready=1.
            chk($sformatf("v%0d a_level", i), 32'(a_level), 32'(tbl[i].ev));
            chk($sformatf("v%0d b_level", i), 32'(b_level), 32'(tbl[i].ev && !tbl[i].evt[10]));
        end
        drain("table");

        // Overflow: the fifth make is dropped in the depth-4 FIFO.
        do_reset();
        begin
            logic [7:0] codes[5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
            for (int i = 0; i < 5; i++) begin
                if (i < 4) exp_q.push_back({3'b000, codes[i]});
                exp_b_q.push_back({3'b000, codes[i]});
                send_byte(codes[i]);
            end
        end
        chk("ovf a_level", 32'(a_level), 4);
        chk("ovf a_overflow", 32'(a_ovf), 1);
        chk("ovf a_press_cnt", 32'(a_cnt), 5);
        chk("ovf a_held_code", 32'(a_hcode), 32'h2C);
        chk("ovf b_level", 32'(b_level), 5);
        chk("ovf b_overflow", 32'(b_ovf), 0);
        @(posedge clk);
        #1;
        chk("ovf a_head_stable", 32'({a_valid, a_code}), 32'h115);
        drain("ovf");
        chk("ovf a_overflow_sticky", 32'(a_ovf), 1);

        // Full FIFO, with a push and a pop in the same cycle.
        do_reset();
        begin
            logic [7:0] codes[4] = '{8'h15, 8'h1D, 8'h24, 8'h2D};
            for (int i = 0; i < 4; i++) begin
                exp_q.push_back({3'b000, codes[i]});
                exp_b_q.push_back({3'b000, codes[i]});
                send_byte(codes[i]);
            end
        end
        chk("full a_level", 32'(a_level), 4);
        @(posedge clk);
        #1;
        byte_data  = 8'h1B;
        byte_valid = 1'b1;
        evt_ready  = 1'b1;
        exp_q.push_back(11'h01B);
        exp_b_q.push_back(11'h01B);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        evt_ready  = 1'b0;
        chk("pushpop a_level", 32'(a_level), 4);
        chk("pushpop a_overflow", 32'(a_ovf), 0);
        chk("pushpop b_level", 32'(b_level), 4);
        drain("pushpop");

        // Reset partway through a prefix sequence.
        do_reset();
        send_byte(8'hE0);
        chk("midrst state_ext", 32'(a_state), 1);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check_zero("midrst");
        chk("midrst state_idle", 32'(a_state), 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        evt_ready = 1'b1;
        exp_q.push_back(11'h01C);
        exp_b_q.push_back(11'h01C);
        send_byte(8'h1C);
        chk("midrst press_cnt", 32'(a_cnt), 1);
        chk("midrst held", 32'({a_hval, a_hext, a_hcode}), 32'h21C);
        drain("midrst");

        chk("final a_queue_empty", 32'(exp_q.size()), 0);
        chk("final b_queue_empty", 32'(exp_b_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
